// File: rtl/osc_clken_gen.sv
// osc_clken_gen: NUM_CH programmable clock-enable channels with a power-up settle period and SYNC realign.
// Define OSC_CLKEN_TOGGLE_EN to add the per-channel TOGGLE square-wave outputs.
module osc_clken_gen #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned DIV_W       = 16,
   parameter int unsigned DIV_DEFAULT = 50,
   parameter int unsigned STARTUP_CYC = 1024,
   localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              CLK,
   input  logic              RESETN,
   input  logic              CFG_VALID,
   output logic              CFG_READY,
   input  logic [CH_W-1:0]   CFG_CH,
   input  logic [DIV_W-1:0]  CFG_DIV,
   output logic              CFG_ERR,
   input  logic              SYNC,
   output logic              READY,
   output logic [NUM_CH-1:0] CLKEN
`ifdef OSC_CLKEN_TOGGLE_EN
   ,
   output logic [NUM_CH-1:0] TOGGLE
`endif
);

   localparam int unsigned      SU_W     = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;
   localparam logic [SU_W-1:0]  SU_INIT  = SU_W'(STARTUP_CYC - 1);
   localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_DEFAULT);
   localparam logic [DIV_W-1:0] CNT_INIT = DIV_W'(DIV_DEFAULT - 1);
   localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(NUM_CH);

   typedef enum logic {ST_STARTUP, ST_RUN} state_t;

   state_t            state_q, state_d;
   logic [SU_W-1:0]   su_cnt_q;
   logic [DIV_W-1:0]  div_q      [NUM_CH];
   logic [DIV_W-1:0]  pend_div_q [NUM_CH];
   logic [DIV_W-1:0]  cnt_q      [NUM_CH];
   logic [NUM_CH-1:0] pending_q;
   logic              cfg_err_q;

   logic              ch_ok, cfg_fire, cfg_bad, run, sync_run;
   logic [NUM_CH-1:0] cfg_hit, tc;

   always_ff @(posedge CLK) begin
      if (!RESETN) state_q <= ST_STARTUP;
      else         state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_STARTUP: if (su_cnt_q == '0) state_d = ST_RUN;
         ST_RUN:     state_d = ST_RUN;
      endcase
   end

   always_comb begin
      ch_ok     = {1'b0, CFG_CH} < CH_LIMIT;
      CFG_READY = RESETN && !(ch_ok && pending_q[CFG_CH]);
      cfg_fire  = CFG_VALID && CFG_READY;
      cfg_bad   = cfg_fire && (!ch_ok || (CFG_DIV == '0));
      run       = (state_q == ST_RUN);
      sync_run  = run && SYNC;
      for (int i = 0; i < NUM_CH; i++) begin
         cfg_hit[i] = cfg_fire && !cfg_bad && (CFG_CH == CH_W'(i));
         tc[i]      = run && (cnt_q[i] == '0);
      end
      // SYNC suppresses even a coincident terminal count.
      CLKEN = sync_run ? '0 : tc;
   end

   assign READY   = run;
   assign CFG_ERR = cfg_err_q;

   // NOTE: the divisor/counter arrays are reset explicitly: a reset must restore DIV_DEFAULT everywhere.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         pending_q <= '0;
         cfg_err_q <= 1'b0;
         su_cnt_q  <= SU_INIT;
         for (int i = 0; i < NUM_CH; i++) begin
            div_q[i]      <= DIV_INIT;
            pend_div_q[i] <= DIV_INIT;
            cnt_q[i]      <= CNT_INIT;
         end
      end else begin
         cfg_err_q <= cfg_bad;
         if (!run && su_cnt_q != '0) su_cnt_q <= su_cnt_q - 1'b1;
         for (int i = 0; i < NUM_CH; i++) begin
            if (!run || sync_run) begin
               // Counters sit at the reload value of the newest divisor (direct write, then pending).
               if (cfg_hit[i]) begin
                  div_q[i] <= CFG_DIV;
                  cnt_q[i] <= CFG_DIV - 1'b1;
               end else if (pending_q[i]) begin
                  div_q[i] <= pend_div_q[i];
                  cnt_q[i] <= pend_div_q[i] - 1'b1;
               end else begin
                  cnt_q[i] <= div_q[i] - 1'b1;
               end
               pending_q[i] <= 1'b0;
            end else begin
               if (tc[i]) begin
                  // The pending divisor only takes over at a reload, so no period is cut short.
                  if (pending_q[i]) begin
                     div_q[i]     <= pend_div_q[i];
                     cnt_q[i]     <= pend_div_q[i] - 1'b1;
                     pending_q[i] <= 1'b0;
                  end else begin
                     cnt_q[i] <= div_q[i] - 1'b1;
                  end
               end else begin
                  cnt_q[i] <= cnt_q[i] - 1'b1;
               end
               if (cfg_hit[i]) begin
                  pending_q[i]  <= 1'b1;
                  pend_div_q[i] <= CFG_DIV;
               end
            end
         end
      end
   end

`ifdef OSC_CLKEN_TOGGLE_EN
   logic [NUM_CH-1:0] toggle_q;

   always_ff @(posedge CLK) begin
      if (!RESETN || sync_run) toggle_q <= '0;
      else                     toggle_q <= toggle_q ^ CLKEN;
   end

   assign TOGGLE = toggle_q;
`endif

endmodule
